instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the 17-bit processor: the producing end of the `Instr` bus that the controller decodes. It issues word reads to instruction memory, buffers up to two returned instructions, and presents them with a valid/ready handshake to the controller/decode stage. On `PCSrc` it redirects the PC to the branch target and squashes in-flight and buffered instructions.

## Interface
- `ADDR_W`, 16: instruction address width; word-addressed, one 17-bit instruction per word.
- `RESET_PC`, 0: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 resets all state.
- `imem_req` out 1: single-cycle read request pulse.
- `imem_addr` out ADDR_W: read address; meaningful when `imem_req`=1.
- `imem_rvalid` in 1: read data valid; at least 1 cycle after `imem_req`; at most one outstanding.
- `imem_rdata` in 17: returned instruction.
- `instr` out 17: instruction to controller (`[16:15]` op, `[16:11]` decode field).
- `instr_valid` out 1: `instr` holds a live instruction.
- `instr_ready` in 1: consumer accepts `instr` this cycle.
- `instr_pc` out ADDR_W: address of `instr`.
- `pc_src` in 1: redirect, from controller `PCSrc`.
- `pc_target` in ADDR_W: redirect address; sampled when `pc_src`=1.

## Operation
- Registers: `pc`, output slot (`instr`, `instr_pc`, `instr_valid`), skid slot (data, pc, valid), and a state register.
- States:
  - S_REQ: `imem_req` = !`pc_src`; `imem_addr` = `pc`.
    - `pc_src` → `pc`<=`pc_target`, stay in S_REQ.
    - Otherwise → S_WAIT.
  - S_WAIT: waiting for `imem_rvalid`.
    - rvalid & `pc_src` → discard data, `pc`<=target, go to S_REQ.
    - rvalid & output slot free → load output slot with (rdata, `pc`), `pc`<=`pc`+1, go to S_REQ.
      - Free means !`instr_valid` | `instr_ready`.
    - rvalid & output slot not free → load skid slot, `pc`<=`pc`+1, go to S_FULL.
    - !rvalid & `pc_src` → `pc`<=target, go to S_DROP.
  - S_DROP: `imem_req`=0.
    - rvalid → discard data, go to S_REQ.
    - `pc_src` → update `pc`, stay in S_DROP until rvalid.
  - S_FULL: `imem_req`=0.
    - `instr_ready` → skid moves to output slot, skid clears, go to S_REQ.
    - `pc_src` → flush both slots, `pc`<=target, go to S_REQ.
- Handshake:
  - Transfer happens on `instr_valid` & `instr_ready`.
  - Output is stable while valid & !ready.
  - Output clears after transfer unless it is reloaded in the same cycle.
- Redirect:
  - `pc_src`=1 clears `instr_valid` and the skid slot next cycle, in every state.
  - The instruction transferred in the same cycle still counts as consumed.
  - `pc_src` has priority over rvalid and `instr_ready` for all state and `pc` updates.
- PC arithmetic is modulo 2^ADDR_W: `pc` = 2^ADDR_W−1 increments to 0.
- Reset values:
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_valid`=0, `instr_pc`=0.
  - Internal: skid slot empty, `pc`=`RESET_PC`, state S_REQ.
- Reset asserted mid-transaction abandons the outstanding read. The memory must also be reset, so no stale rvalid follows.

## Timing
- First `imem_req` occurs in the first rising edge cycle after `reset` deasserts.
- `imem_rvalid` latency L≥1 gives `instr_valid` L+1 cycles after `imem_req`.
- Peak throughput is 1 instruction per (L+1) cycles; with L=1, 1 per 2 cycles.
- `pc_src` in cycle t → `imem_req` to `pc_target` no earlier than t+1 (S_REQ/S_WAIT path); it is delayed until rvalid if a read is outstanding.
- No combinational path from `imem_rdata` to `instr`. `imem_req` depends combinationally on `pc_src` in S_REQ only.

## Configuration
- `IFETCH_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` (16 bits, reset 0).
  - Increments on every discarded response and on every flushed valid slot (both slots flushed in one cycle count 2); saturates at 0xFFFF.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W`=17.
  - Opcode constants `OP_DATA`=2'b00, `OP_MEM`=2'b01, `OP_CTRL`=2'b10.
  - `typedef enum` `ifetch_state_t` {S_REQ, S_WAIT, S_DROP, S_FULL}.
- Sub-module `ifetch_skid`: the output and skid slots with the valid/ready and flush logic. The FSM and PC stay in `instr_fetch`.

## Test plan
- Reset release with L=1, `instr_ready`=1, memory returning word n: requests at 0,1,2,…; `instr`=17'b00_0_00_0010_0001_0011 at `instr_pc`=0 two cycles after the first request; one instruction every 2 cycles.
- `instr_ready`=0 for 6 cycles: two instructions buffered (pc 0 and 1), state S_FULL, `imem_req`=0; on ready they transfer on consecutive cycles, then fetch resumes at pc 2.
- L=3 and `pc_src`=1, `pc_target`=0x0040 one cycle after the request to 5: the response for 5 is discarded; next request to 0x0040; `instr_pc`=0x0040 appears with data at 0x40.
- `pc_src` in the same cycle as `imem_rvalid`: the response is dropped, `instr_valid`=0 next cycle, and a request to the target issues the following cycle.
- `pc` at 0xFFFF: next request to 0x0000.
- Reset pulled low while in S_WAIT with both slots full: outputs return to reset values immediately (asynchronously); `IFETCH_DROP_CNT_EN` `drop_cnt` returns to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 17-bit processor: instruction width, opcode
// field values and the fetch-unit state encoding.
package cpu_pkg;

    localparam int INSTR_W = 17;

    localparam logic [1:0] OP_DATA = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_CTRL = 2'b10;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_FULL
    } ifetch_state_t;

    function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] word);
        return word[16:15];
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// Two-entry output buffer for the fetch unit: the output slot presented to
// decode plus a skid slot that catches a response arriving while decode stalls.
module ifetch_skid
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               flush,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               skid_valid,
    output logic               slot_free
);

    logic [INSTR_W-1:0] out_data_reg;
    logic [ADDR_W-1:0]  out_pc_reg;
    logic               out_valid_reg;
    logic [INSTR_W-1:0] skid_data_reg;
    logic [ADDR_W-1:0]  skid_pc_reg;
    logic               skid_valid_reg;

    // The output slot can take new data if empty or being consumed this cycle.
    assign slot_free = !out_valid_reg || instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_reg   <= '0;
            out_pc_reg     <= '0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_pc_reg    <= '0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg && instr_ready) begin
            out_data_reg   <= skid_data_reg;
            out_pc_reg     <= skid_pc_reg;
            out_valid_reg  <= 1'b1;
            skid_valid_reg <= 1'b0;
        end else if (load && slot_free) begin
            out_data_reg  <= load_data;
            out_pc_reg    <= load_pc;
            out_valid_reg <= 1'b1;
        end else if (load) begin
            skid_data_reg  <= load_data;
            skid_pc_reg    <= load_pc;
            skid_valid_reg <= 1'b1;
        end else if (instr_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign instr       = out_data_reg;
    assign instr_pc    = out_pc_reg;
    assign instr_valid = out_valid_reg;
    assign skid_valid  = skid_valid_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding word reads, two-deep output
// buffering and pc_src redirect. Define IFETCH_DROP_CNT_EN to add drop_cnt.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  pc_target
`ifdef IFETCH_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    ifetch_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              load;
    logic              slot_free;
    logic              skid_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_REQ;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            S_REQ: begin
                if (pc_src) pc_next = pc_target;
                else        state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (pc_src) begin
                        pc_next    = pc_target;
                        state_next = S_REQ;
                    end else begin
                        pc_next    = pc_reg + ADDR_W'(1);
                        state_next = slot_free ? S_REQ : S_FULL;
                    end
                end else if (pc_src) begin
                    pc_next    = pc_target;
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (pc_src)      pc_next = pc_target;
                if (imem_rvalid) state_next = S_REQ;
            end
            S_FULL: begin
                // An empty skid here can only follow a flush; never park in S_FULL.
                if (pc_src) begin
                    pc_next    = pc_target;
                    state_next = S_REQ;
                end else if (instr_ready || !skid_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // imem_req is gated by reset so it reads 0 for as long as reset is held.
    always_comb begin
        imem_req  = reset && (state_reg == S_REQ) && !pc_src;
        imem_addr = pc_reg;
        load      = (state_reg == S_WAIT) && imem_rvalid && !pc_src;
    end

    ifetch_skid #(
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (imem_rdata),
        .load_pc    (pc_reg),
        .flush      (pc_src),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .skid_valid (skid_valid),
        .slot_free  (slot_free)
    );

`ifdef IFETCH_DROP_CNT_EN
    logic        discard;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;
    logic [15:0] drop_cnt_reg;

    // A slot being transferred in the redirect cycle counts as consumed, not dropped.
    always_comb begin
        discard  = imem_rvalid && (((state_reg == S_WAIT) && pc_src) || (state_reg == S_DROP));
        drop_inc = 2'(discard)
                 + 2'(pc_src && instr_valid && !instr_ready)
                 + 2'(pc_src && skid_valid);
        drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_inc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_reg <= '0;
        else        drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a latency-programmable memory model, a
// transaction-level fetch model and directed plus random redirect/stall traffic.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [16:0] imem_rdata;
    logic [16:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic        pc_src;
    logic [15:0] pc_target;
`ifdef IFETCH_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    instr_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_pc   (instr_pc),
        .pc_src     (pc_src),
        .pc_target  (pc_target)
`ifdef IFETCH_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: word 0 holds 17'b00_0_00_0010_0001_0011.
    function automatic logic [16:0] memf(input logic [15:0] a);
        return 17'h00213 ^ {1'b0, a} ^ {a[7:0], 9'b0};
    endfunction

    typedef struct {
        logic [16:0] d;
        logic [15:0] a;
    } ent_t;

    // memory model state
    int          lat = 1;
    logic        mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_addr = '0;
    logic        rv_next = 1'b0;
    logic [16:0] rd_next = '0;

    // reference model state
    ent_t        q[$];
    logic [15:0] exp_pc = '0;
    logic [15:0] out_addr = '0;
    logic        outstanding = 1'b0;
    logic        squash = 1'b0;
    logic        prev_pc_src = 1'b0;
    int          drop_exp = 0;
    int          cyc = 0;
    int          first_req_cyc = -1;
    int          first_val_cyc = -1;
    logic [16:0] first_instr = '0;
    logic [15:0] first_pc = '0;
    int          last_xfer = -1;
    logic        period_chk = 1'b0;

    always @(posedge clk) begin
        #1;
        imem_rvalid = rv_next;
        imem_rdata  = rv_next ? rd_next : 17'h0;
    end

    // Monitor, then model update, then memory update, all on the inactive edge.
    always @(negedge clk) begin
        ent_t e;
        int   qs;
        logic exp_req;
        cyc++;
        if (!reset) begin
            q.delete();
            exp_pc        = 16'h0000;
            outstanding   = 1'b0;
            squash        = 1'b0;
            prev_pc_src   = 1'b0;
            drop_exp      = 0;
            first_req_cyc = -1;
            first_val_cyc = -1;
            last_xfer     = -1;
            mem_pending   = 1'b0;
            rv_next       = 1'b0;
        end else begin
`ifdef IFETCH_DROP_CNT_EN
            chk("drop_cnt", {16'h0, drop_cnt}, (drop_exp > 65535) ? 32'hFFFF : drop_exp);
`endif
            if (prev_pc_src) chk("valid_after_redirect", instr_valid, 1'b0);
            chk("valid_vs_model", instr_valid, q.size() != 0);
            qs = q.size();
            if (instr_valid && qs != 0) begin
                if (first_val_cyc < 0) begin
                    first_val_cyc = cyc;
                    first_instr   = instr;
                    first_pc      = instr_pc;
                end
                if (instr_ready) begin
                    e = q.pop_front();
                    chk("xfer_instr", instr, e.d);
                    chk("xfer_pc", instr_pc, e.a);
                    $display("xfer pc=%04h instr=%05h cyc=%0d", instr_pc, instr, cyc);
                    if (period_chk && last_xfer >= 0) chk("period", cyc - last_xfer, 2);
                    last_xfer = cyc;
                end
            end
            exp_req = !pc_src && !outstanding && (qs < 2);
            chk("imem_req", imem_req, exp_req);
            if (imem_rvalid) begin
                if (pc_src || squash) begin
                    drop_exp++;
                end else begin
                    e.d = memf(out_addr);
                    e.a = out_addr;
                    q.push_back(e);
                    exp_pc = 16'(out_addr + 16'd1);
                end
                outstanding = 1'b0;
                squash      = 1'b0;
            end
            if (imem_req) begin
                chk("imem_addr", imem_addr, exp_pc);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                outstanding = 1'b1;
                squash      = 1'b0;
                out_addr    = imem_addr;
            end
            if (pc_src) begin
                drop_exp += q.size();
                q.delete();
                exp_pc = pc_target;
                if (outstanding) squash = 1'b1;
            end
            prev_pc_src = pc_src;

            if (imem_req) begin
                mem_pending = 1'b1;
                mem_cnt     = lat;
                mem_addr    = imem_addr;
            end
            rv_next = 1'b0;
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    rv_next     = 1'b1;
                    rd_next     = memf(mem_addr);
                    mem_pending = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        reset       = 1'b0;
        instr_ready = 1'b1;
        pc_src      = 1'b0;
        pc_target   = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        step();
        step();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 17'h0);
        chk("rst_pc", instr_pc, 16'h0000);

        // streaming with L=1 and decode always ready
        reset      = 1'b1;
        period_chk = 1'b1;
        repeat (24) step();
        period_chk = 1'b0;
        chk("first_latency", first_val_cyc - first_req_cyc, 2);
        chk("first_instr", first_instr, 17'b00_0_00_0010_0001_0011);
        chk("first_pc", first_pc, 16'h0000);

        // decode stalls: both slots fill, fetch pauses, then drains back-to-back
        instr_ready = 1'b0;
        do_reset();
        repeat (6) step();
        @(negedge clk);
        chk("full_valid", instr_valid, 1'b1);
        chk("full_pc0", instr_pc, 16'h0000);
        chk("full_noreq", imem_req, 1'b0);
        step();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("drain_pc0", instr_pc, 16'h0000);
        @(negedge clk);
        chk("drain_valid1", instr_valid, 1'b1);
        chk("drain_pc1", instr_pc, 16'h0001);
        chk("resume_req", imem_req, 1'b1);
        chk("resume_addr", imem_addr, 16'h0002);

        // L=3, redirect one cycle after the request to 5
        lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 16'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_req5", found, 1'b1);
        step();
        pc_src    = 1'b1;
        pc_target = 16'h0040;
        step();
        pc_src = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("redirect_req_seen", found, 1'b1);
        chk("redirect_req_addr", imem_addr, 16'h0040);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("redirect_valid_seen", found, 1'b1);
        chk("redirect_instr_pc", instr_pc, 16'h0040);
        chk("redirect_instr", instr, memf(16'h0040));

        // redirect in the same cycle as the memory response
        lat = 2;
        step();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (rv_next) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_rvalid", found, 1'b1);
        step();
        pc_src    = 1'b1;
        pc_target = 16'h1234;
        step();
        pc_src = 1'b0;
        @(negedge clk);
        chk("same_cycle_valid", instr_valid, 1'b0);
        chk("same_cycle_req", imem_req, 1'b1);
        chk("same_cycle_addr", imem_addr, 16'h1234);

        // PC wrap at the top of the address space
        lat = 1;
        step();
        pc_src    = 1'b1;
        pc_target = 16'hFFFE;
        step();
        pc_src = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 16'hFFFF) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_req_ffff", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap_req_seen", found, 1'b1);
        chk("wrap_addr", imem_addr, 16'h0000);

        // random stalls, redirects and latencies
        for (int i = 0; i < 1500; i++) begin
            step();
            instr_ready = ($urandom_range(3) != 0);
            pc_src      = ($urandom_range(15) == 0);
            pc_target   = ($urandom_range(3) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFF8))
                                                   : 16'($urandom);
            if ($urandom_range(63) == 0) lat = $urandom_range(4, 1);
        end

        // asynchronous reset with both slots full
        step();
        pc_src      = 1'b0;
        instr_ready = 1'b0;
        repeat (8) step();
        chk("pre_reset_valid", instr_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 1'b0);
        chk("async_rst_addr", imem_addr, 16'h0000);
        chk("async_rst_valid", instr_valid, 1'b0);
        chk("async_rst_instr", instr, 17'h0);
        chk("async_rst_pc", instr_pc, 16'h0000);
`ifdef IFETCH_DROP_CNT_EN
        chk("async_rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
`endif
        step();
        step();
        instr_ready = 1'b1;
        reset       = 1'b1;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
